// File: rtl/decode_ctrl_unit_pkg.sv
// Shared encodings for the D-stage decoder: opcodes, functs, extender codes,
// hazard timing codes and the branch-kind classifier.
package decode_ctrl_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned REG_AW  = 5;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;

    // Tuse: stage distance before an operand is consumed; NONE marks an unused operand.
    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] TNEW_NONE = 2'd0;
    localparam logic [1:0] TNEW_LINK = 2'd1;
    localparam logic [1:0] TNEW_ALU  = 2'd2;
    localparam logic [1:0] TNEW_LOAD = 2'd3;

    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ
    } br_kind_t;

    typedef struct packed {
        logic       is_br;
        logic       is_jump;
        logic       is_jr;
        logic [1:0] ext_ctrl;
        logic       imm_sel;
        logic       reg_write;
        logic       mdu_start;
        logic       mdu_class;
        logic [1:0] tuse1;
        logic [1:0] tuse2;
        logic [1:0] tnew;
    } dec_t;

    function automatic br_kind_t br_kind(input logic [5:0] op, input logic [4:0] rt);
        br_kind_t k;
        k = BR_NONE;
        case (op)
            OP_BEQ:    k = BR_EQ;
            OP_BNE:    k = BR_NE;
            OP_BLEZ:   k = BR_LEZ;
            OP_BGTZ:   k = BR_GTZ;
            OP_REGIMM: begin
                if (rt == RT_BLTZ)      k = BR_LTZ;
                else if (rt == RT_BGEZ) k = BR_GEZ;
            end
            default:   k = BR_NONE;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/decode_ctrl_unit_branch_cmp.sv
// Branch condition evaluation on the forwarded rs/rt operands (signed).
module decode_ctrl_unit_branch_cmp
    import decode_ctrl_unit_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    input  logic [INSTR_W-1:0] rdata1,
    input  logic [INSTR_W-1:0] rdata2,
    output logic               if_br
);

    br_kind_t kind;
    logic     a_neg;
    logic     a_zero;
    logic     unused_instr_bits;

    assign kind              = br_kind(instr[31:26], instr[20:16]);
    assign a_neg             = rdata1[INSTR_W-1];
    assign a_zero            = (rdata1 == '0);
    assign unused_instr_bits = ^{instr[25:21], instr[15:0]};

    always_comb begin
        if_br = 1'b0;
        case (kind)
            BR_EQ:   if_br = (rdata1 == rdata2);
            BR_NE:   if_br = (rdata1 != rdata2);
            BR_LEZ:  if_br = a_neg | a_zero;
            BR_GTZ:  if_br = ~a_neg & ~a_zero;
            BR_LTZ:  if_br = a_neg;
            BR_GEZ:  if_br = ~a_neg;
            default: if_br = 1'b0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl_unit.sv
// D-stage control: instruction decode, branch resolution, hazard timing (Tuse/Tnew)
// and the branch-delay-slot flag.
module decode_ctrl_unit
    import decode_ctrl_unit_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] Instr,
    input  logic [INSTR_W-1:0] RData1,
    input  logic [INSTR_W-1:0] RData2,
    output logic               isBr,
    output logic               isJump,
    output logic               isJr,
    output logic               ifBr,
    output logic [1:0]         ExtCtrl,
    output logic               ImmSel,
    output logic               RegWrite,
    output logic               MDUStart,
    output logic               MDUClass,
    output logic [1:0]         Tuse1,
    output logic [1:0]         Tuse2,
    output logic [1:0]         Tnew,
    output logic [REG_AW-1:0]  ReadA1,
    output logic [REG_AW-1:0]  ReadA2,
    output logic               InDelaySlot
);

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    dec_t              dec;
    logic              in_delay_slot_d;
    logic              in_delay_slot_q;

    assign op    = Instr[31:26];
    assign funct = Instr[5:0];
    assign rs    = Instr[25:21];
    assign rt    = Instr[20:16];

    // Anything not decoded below stays a nop with both operands unused.
    always_comb begin
        dec       = '0;
        dec.tuse1 = TUSE_NONE;
        dec.tuse2 = TUSE_NONE;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
                        dec.tuse1     = TUSE_E;
                        dec.tuse2     = TUSE_E;
                        dec.tnew      = TNEW_ALU;
                        dec.reg_write = 1'b1;
                    end
                    FN_SLL: begin
                        if (Instr != '0) begin
                            dec.tuse2     = TUSE_E;
                            dec.tnew      = TNEW_ALU;
                            dec.reg_write = 1'b1;
                        end
                    end
                    FN_JR: begin
                        dec.tuse1 = TUSE_D;
                        dec.is_jr = 1'b1;
                    end
                    FN_JALR: begin
                        dec.tuse1     = TUSE_D;
                        dec.is_jr     = 1'b1;
                        dec.imm_sel   = 1'b1;
                        dec.reg_write = 1'b1;
                        dec.tnew      = TNEW_LINK;
                    end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        dec.tuse1     = TUSE_E;
                        dec.tuse2     = TUSE_E;
                        dec.mdu_start = 1'b1;
                        dec.mdu_class = 1'b1;
                    end
                    FN_MFHI, FN_MFLO: begin
                        dec.tnew      = TNEW_ALU;
                        dec.reg_write = 1'b1;
                        dec.mdu_class = 1'b1;
                    end
                    FN_MTHI, FN_MTLO: begin
                        dec.tuse1     = TUSE_E;
                        dec.mdu_class = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ORI, OP_ANDI, OP_ADDIU: begin
                dec.ext_ctrl  = (op == OP_ADDIU) ? EXT_SIGN : EXT_ZERO;
                dec.tuse1     = TUSE_E;
                dec.tnew      = TNEW_ALU;
                dec.reg_write = 1'b1;
            end
            OP_LUI: begin
                dec.ext_ctrl  = EXT_LUI;
                dec.tnew      = TNEW_LINK;
                dec.reg_write = 1'b1;
            end
            OP_LW: begin
                dec.ext_ctrl  = EXT_SIGN;
                dec.tuse1     = TUSE_E;
                dec.tnew      = TNEW_LOAD;
                dec.reg_write = 1'b1;
            end
            OP_SW: begin
                dec.ext_ctrl = EXT_SIGN;
                dec.tuse1    = TUSE_E;
                dec.tuse2    = TUSE_M;
            end
            OP_BEQ, OP_BNE: begin
                dec.ext_ctrl = EXT_SIGN;
                dec.tuse1    = TUSE_D;
                dec.tuse2    = TUSE_D;
                dec.is_br    = 1'b1;
            end
            OP_BLEZ, OP_BGTZ: begin
                dec.tuse1 = TUSE_D;
                dec.is_br = 1'b1;
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ) begin
                    dec.tuse1 = TUSE_D;
                    dec.is_br = 1'b1;
                end
            end
            OP_J: begin
                dec.is_jump = 1'b1;
            end
            OP_JAL: begin
                dec.is_jump   = 1'b1;
                dec.imm_sel   = 1'b1;
                dec.reg_write = 1'b1;
                dec.tnew      = TNEW_LINK;
            end
            default: ;
        endcase
    end

    decode_ctrl_unit_branch_cmp u_branch_cmp (
        .instr  (Instr),
        .rdata1 (RData1),
        .rdata2 (RData2),
        .if_br  (ifBr)
    );

    assign isBr     = dec.is_br;
    assign isJump   = dec.is_jump;
    assign isJr     = dec.is_jr;
    assign ExtCtrl  = dec.ext_ctrl;
    assign ImmSel   = dec.imm_sel;
    assign RegWrite = dec.reg_write;
    assign MDUStart = dec.mdu_start;
    assign MDUClass = dec.mdu_class;
    assign Tuse1    = dec.tuse1;
    assign Tuse2    = dec.tuse2;
    assign Tnew     = dec.tnew;
    assign ReadA1   = (dec.tuse1 != TUSE_NONE) ? rs : '0;
    assign ReadA2   = (dec.tuse2 != TUSE_NONE) ? rt : '0;

    // No enable: a stalled D instruction re-evaluates to the same value.
    assign in_delay_slot_d = dec.is_br | dec.is_jump | dec.is_jr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) in_delay_slot_q <= 1'b0;
        else       in_delay_slot_q <= in_delay_slot_d;
    end

    assign InDelaySlot = in_delay_slot_q;

endmodule

// File: tb/tb_decode_ctrl_unit.sv
// Directed and randomized checks of decode_ctrl_unit against a mnemonic-level
// reference model of the instruction table.
module tb_decode_ctrl_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [31:0] RData1;
    logic [31:0] RData2;
    logic        isBr, isJump, isJr, ifBr, ImmSel, RegWrite, MDUStart, MDUClass;
    logic [1:0]  ExtCtrl, Tuse1, Tuse2, Tnew;
    logic [4:0]  ReadA1, ReadA2;
    logic        InDelaySlot;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       br, jmp, jr, ifbr;
        logic [1:0] ext;
        logic       imm, rw, mstart, mclass;
        logic [1:0] t1, t2, tn;
        logic [4:0] a1, a2;
    } exp_t;

    decode_ctrl_unit dut (
        .clk         (clk),
        .reset       (reset),
        .Instr       (Instr),
        .RData1      (RData1),
        .RData2      (RData2),
        .isBr        (isBr),
        .isJump      (isJump),
        .isJr        (isJr),
        .ifBr        (ifBr),
        .ExtCtrl     (ExtCtrl),
        .ImmSel      (ImmSel),
        .RegWrite    (RegWrite),
        .MDUStart    (MDUStart),
        .MDUClass    (MDUClass),
        .Tuse1       (Tuse1),
        .Tuse2       (Tuse2),
        .Tnew        (Tnew),
        .ReadA1      (ReadA1),
        .ReadA2      (ReadA2),
        .InDelaySlot (InDelaySlot)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h (Instr=%h)", tag, obs, exp, Instr);
        end
    endtask

    function automatic string mnemonic(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (ins == 32'h0) return "nop";
        case (op)
            6'd0: case (fn)
                6'h21: return "addu";   6'h23: return "subu";
                6'h24: return "and";    6'h25: return "or";
                6'h2a: return "slt";    6'h00: return "sll";
                6'h08: return "jr";     6'h09: return "jalr";
                6'h18: return "mult";   6'h19: return "multu";
                6'h1a: return "div";    6'h1b: return "divu";
                6'h10: return "mfhi";   6'h12: return "mflo";
                6'h11: return "mthi";   6'h13: return "mtlo";
                default: return "?";
            endcase
            6'h0d: return "ori";   6'h0c: return "andi";
            6'h09: return "addiu"; 6'h0f: return "lui";
            6'h23: return "lw";    6'h2b: return "sw";
            6'h04: return "beq";   6'h05: return "bne";
            6'h06: return "blez";  6'h07: return "bgtz";
            6'h01: return (ins[20:16] == 5'd0) ? "bltz" : (ins[20:16] == 5'd1) ? "bgez" : "?";
            6'h02: return "j";     6'h03: return "jal";
            default: return "?";
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa;
        e = '0;
        e.t1 = 2'd3;
        e.t2 = 2'd3;
        sa = int'(a);
        case (mnemonic(ins))
            "addu", "subu", "and", "or", "slt": begin e.t1 = 1; e.t2 = 1; e.tn = 2; e.rw = 1; end
            "sll":   begin e.t2 = 1; e.tn = 2; e.rw = 1; end
            "jr":    begin e.t1 = 0; e.jr = 1; end
            "jalr":  begin e.t1 = 0; e.jr = 1; e.imm = 1; e.rw = 1; e.tn = 1; end
            "mult", "multu", "div", "divu": begin e.t1 = 1; e.t2 = 1; e.mstart = 1; e.mclass = 1; end
            "mfhi", "mflo": begin e.tn = 2; e.rw = 1; e.mclass = 1; end
            "mthi", "mtlo": begin e.t1 = 1; e.mclass = 1; end
            "ori", "andi":  begin e.ext = 0; e.t1 = 1; e.tn = 2; e.rw = 1; end
            "addiu": begin e.ext = 1; e.t1 = 1; e.tn = 2; e.rw = 1; end
            "lui":   begin e.ext = 2; e.tn = 1; e.rw = 1; end
            "lw":    begin e.ext = 1; e.t1 = 1; e.tn = 3; e.rw = 1; end
            "sw":    begin e.ext = 1; e.t1 = 1; e.t2 = 2; end
            "beq":   begin e.ext = 1; e.t1 = 0; e.t2 = 0; e.br = 1; e.ifbr = (a == b); end
            "bne":   begin e.ext = 1; e.t1 = 0; e.t2 = 0; e.br = 1; e.ifbr = (a != b); end
            "blez":  begin e.t1 = 0; e.br = 1; e.ifbr = (sa <= 0); end
            "bgtz":  begin e.t1 = 0; e.br = 1; e.ifbr = (sa > 0); end
            "bltz":  begin e.t1 = 0; e.br = 1; e.ifbr = (sa < 0); end
            "bgez":  begin e.t1 = 0; e.br = 1; e.ifbr = (sa >= 0); end
            "j":     e.jmp = 1;
            "jal":   begin e.jmp = 1; e.imm = 1; e.rw = 1; e.tn = 1; end
            default: ;
        endcase
        e.a1 = (e.t1 != 2'd3) ? ins[25:21] : 5'd0;
        e.a2 = (e.t2 != 2'd3) ? ins[20:16] : 5'd0;
        return e;
    endfunction

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".isBr"},     32'(isBr),     32'(e.br));
        chk({tag, ".isJump"},   32'(isJump),   32'(e.jmp));
        chk({tag, ".isJr"},     32'(isJr),     32'(e.jr));
        chk({tag, ".ifBr"},     32'(ifBr),     32'(e.ifbr));
        chk({tag, ".ExtCtrl"},  32'(ExtCtrl),  32'(e.ext));
        chk({tag, ".ImmSel"},   32'(ImmSel),   32'(e.imm));
        chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(e.rw));
        chk({tag, ".MDUStart"}, 32'(MDUStart), 32'(e.mstart));
        chk({tag, ".MDUClass"}, 32'(MDUClass), 32'(e.mclass));
        chk({tag, ".Tuse1"},    32'(Tuse1),    32'(e.t1));
        chk({tag, ".Tuse2"},    32'(Tuse2),    32'(e.t2));
        chk({tag, ".Tnew"},     32'(Tnew),     32'(e.tn));
        chk({tag, ".ReadA1"},   32'(ReadA1),   32'(e.a1));
        chk({tag, ".ReadA2"},   32'(ReadA2),   32'(e.a2));
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
        Instr  = ins;
        RData1 = a;
        RData2 = b;
        #1;
    endtask

    // {op, funct} templates; funct only matters for op 0.
    logic [11:0] tmpl [0:27] = '{
        {6'h00, 6'h21}, {6'h00, 6'h23}, {6'h00, 6'h24}, {6'h00, 6'h25}, {6'h00, 6'h2a},
        {6'h00, 6'h00}, {6'h00, 6'h08}, {6'h00, 6'h09}, {6'h00, 6'h18}, {6'h00, 6'h19},
        {6'h00, 6'h1a}, {6'h00, 6'h1b}, {6'h00, 6'h10}, {6'h00, 6'h12}, {6'h00, 6'h11},
        {6'h00, 6'h13}, {6'h0d, 6'h00}, {6'h0c, 6'h00}, {6'h09, 6'h00}, {6'h0f, 6'h00},
        {6'h23, 6'h00}, {6'h2b, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h00}, {6'h06, 6'h00},
        {6'h07, 6'h00}, {6'h01, 6'h00}, {6'h03, 6'h00}
    };

    logic [31:0] br_val [0:2] = '{32'h8000_0000, 32'h0, 32'h1};
    logic [31:0] br_ins [0:3] = '{32'h0420_0004, 32'h0421_0004, 32'h1820_0004, 32'h1C20_0004};
    // Expected ifBr for br_val[0..2], packed as bits [2:0] = {v0, v1, v2}.
    logic [2:0]  br_exp [0:3] = '{3'b100, 3'b011, 3'b110, 3'b001};

    initial begin
        logic [31:0] ins;
        logic [31:0] a;
        logic [31:0] b;
        logic [11:0] t;
        logic [2:0]  eb;
        exp_t        e;
        logic        prev_flow;

        reset = 1'b1;
        drive(32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("reset.InDelaySlot", 32'(InDelaySlot), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        drive(32'h0022_1821, 32'h0, 32'h0);
        chk("addu.RegWrite", 32'(RegWrite), 32'd1);
        chk("addu.Tuse1", 32'(Tuse1), 32'd1);
        chk("addu.Tuse2", 32'(Tuse2), 32'd1);
        chk("addu.Tnew", 32'(Tnew), 32'd2);
        chk("addu.ReadA1", 32'(ReadA1), 32'd1);
        chk("addu.ReadA2", 32'(ReadA2), 32'd2);
        chk("addu.isBr", 32'(isBr), 32'd0);

        drive(32'h1022_0004, 32'd5, 32'd5);
        chk("beq.isBr", 32'(isBr), 32'd1);
        chk("beq.ifBr_eq", 32'(ifBr), 32'd1);
        chk("beq.Tuse1", 32'(Tuse1), 32'd0);
        chk("beq.Tuse2", 32'(Tuse2), 32'd0);
        drive(32'h1022_0004, 32'd5, 32'd6);
        chk("beq.ifBr_ne", 32'(ifBr), 32'd0);
        @(posedge clk); #1;
        chk("beq.InDelaySlot", 32'(InDelaySlot), 32'd1);
        @(negedge clk);
        drive(32'h0022_1821, 32'h0, 32'h0);
        @(posedge clk); #1;
        chk("addu.InDelaySlot", 32'(InDelaySlot), 32'd0);
        @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            eb = br_exp[i];
            for (int j = 0; j < 3; j++) begin
                drive(br_ins[i], br_val[j], 32'h0);
                chk($sformatf("sgnbr%0d_%0d.ifBr", i, j), 32'(ifBr), 32'(eb[2-j]));
                chk($sformatf("sgnbr%0d_%0d.isBr", i, j), 32'(isBr), 32'd1);
            end
        end
        drive(32'h0422_0004, 32'h0, 32'h0);
        chk("regimm_unk.isBr", 32'(isBr), 32'd0);
        chk("regimm_unk.ifBr", 32'(ifBr), 32'd0);

        drive(32'h8CA4_0008, 32'h0, 32'h0);
        chk("lw.Tnew", 32'(Tnew), 32'd3);
        chk("lw.ExtCtrl", 32'(ExtCtrl), 32'd1);
        chk("lw.Tuse1", 32'(Tuse1), 32'd1);
        chk("lw.Tuse2", 32'(Tuse2), 32'd3);
        chk("lw.ReadA2", 32'(ReadA2), 32'd0);
        drive(32'hACA4_0008, 32'h0, 32'h0);
        chk("sw.Tuse2", 32'(Tuse2), 32'd2);
        chk("sw.RegWrite", 32'(RegWrite), 32'd0);

        drive(32'h0C00_0010, 32'h0, 32'h0);
        chk("jal.isJump", 32'(isJump), 32'd1);
        chk("jal.ImmSel", 32'(ImmSel), 32'd1);
        chk("jal.RegWrite", 32'(RegWrite), 32'd1);
        chk("jal.Tnew", 32'(Tnew), 32'd1);
        drive(32'h03E0_0008, 32'h0, 32'h0);
        chk("jr.isJr", 32'(isJr), 32'd1);
        chk("jr.Tuse1", 32'(Tuse1), 32'd0);
        chk("jr.ReadA1", 32'(ReadA1), 32'd31);

        drive(32'h0022_0018, 32'h0, 32'h0);
        chk("mult.MDUStart", 32'(MDUStart), 32'd1);
        chk("mult.MDUClass", 32'(MDUClass), 32'd1);
        drive(32'h0000_1812, 32'h0, 32'h0);
        chk("mflo.MDUStart", 32'(MDUStart), 32'd0);
        chk("mflo.MDUClass", 32'(MDUClass), 32'd1);
        chk("mflo.Tnew", 32'(Tnew), 32'd2);

        drive(32'h0, 32'h1234, 32'h1234);
        e = '0;
        e.t1 = 2'd3;
        e.t2 = 2'd3;
        check_all("nop", e);

        drive(32'h1022_0004, 32'd7, 32'd7);
        @(posedge clk); #1;
        chk("pre_rst.InDelaySlot", 32'(InDelaySlot), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_rst.InDelaySlot", 32'(InDelaySlot), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h0, 32'h0, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);

        prev_flow = 1'b0;
        for (int it = 0; it < 400; it++) begin
            ins = $urandom;
            if (($urandom % 8) != 0) begin
                t = tmpl[$urandom_range(0, 27)];
                ins[31:26] = t[11:6];
                if (t[11:6] == 6'h00) ins[5:0] = t[5:0];
                if (t[11:6] == 6'h01) ins[20:16] = 5'($urandom_range(0, 2));
            end
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = a; end
                1: begin a = 32'h0; b = $urandom; end
                2: begin a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF; b = $urandom; end
                default: begin a = $urandom; b = $urandom; end
            endcase
            drive(ins, a, b);
            e = model(ins, a, b);
            check_all($sformatf("rnd%0d_%s", it, mnemonic(ins)), e);
            prev_flow = e.br | e.jmp | e.jr;
            @(posedge clk); #1;
            chk($sformatf("rnd%0d.InDelaySlot", it), 32'(InDelaySlot), 32'(prev_flow));
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_ctrl_unit.md
Name: decode_ctrl_unit

Overview:
- Decode-stage control block of the 5-stage MIPS pipeline. It merges three functions:
  - main instruction decode (control signals);
  - branch comparison on the forwarded register operands;
  - hazard-timing info (Tuse/Tnew, source addresses, MDU class) for the hazard/forwarding unit.
- All decode outputs are combinational from Instr and the operands.
- One register tracks the branch delay slot.

Parameters:
- none

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Instr  in  32  instruction in D stage
- RData1  in  32  forwarded rs operand
- RData2  in  32  forwarded rt operand
- isBr  out  1  conditional branch (beq, bne, blez, bgtz, bltz, bgez)
- isJump  out  1  j or jal
- isJr  out  1  jr or jalr
- ifBr  out  1  branch condition true (0 when not a branch)
- ExtCtrl  out  2  00 zero-extend, 01 sign-extend, 10 imm16<<16
- ImmSel  out  1  1 selects link value PC+8 (jal, jalr)
- RegWrite  out  1  instruction writes the GRF
- MDUStart  out  1  mult, multu, div, divu
- MDUClass  out  1  any of mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- Tuse1  out  2  cycles until rs is needed; 3 = unused
- Tuse2  out  2  cycles until rt is needed; 3 = unused
- Tnew  out  2  cycles until the result is available (D-stage view); 0 = none
- ReadA1  out  5  rs if rs is used, else 0
- ReadA2  out  5  rt if rt is used, else 0
- InDelaySlot  out  1  registered; the current D instruction follows a branch or jump

Behaviour:
- Field decode:
  - op = Instr[31:26], funct = Instr[5:0], rt = Instr[20:16].
- R-type (op 000000), by funct:
  - addu 100001, subu 100011, and 100100, or 100101, slt 101010: Tuse1 = 1, Tuse2 = 1, Tnew = 2, RegWrite.
  - sll 000000: rt only, Tuse2 = 1, Tnew = 2, RegWrite. Instr == 0 (nop) drives every output 0, with Tuse1 = Tuse2 = 3.
  - jr 001000: Tuse1 = 0, isJr.
  - jalr 001001: Tuse1 = 0, isJr, ImmSel, RegWrite, Tnew = 1.
  - mult/multu/div/divu 011000/011001/011010/011011: Tuse1 = 1, Tuse2 = 1, MDUStart, MDUClass.
  - mfhi 010000 / mflo 010010: no reads, Tnew = 2, RegWrite, MDUClass.
  - mthi 010001 / mtlo 010011: Tuse1 = 1, MDUClass.
- I-type and jumps:
  - ori 001101, andi 001100: ExtCtrl = 00, Tuse1 = 1, Tnew = 2, RegWrite.
  - addiu 001001: ExtCtrl = 01, Tuse1 = 1, Tnew = 2, RegWrite.
  - lui 001111: ExtCtrl = 10, no reads, Tnew = 1 (result forwarded from E immediate), RegWrite.
  - lw 100011: ExtCtrl = 01, Tuse1 = 1, Tnew = 3, RegWrite.
  - sw 101011: ExtCtrl = 01, Tuse1 = 1, Tuse2 = 2, Tnew = 0.
  - beq 000100 / bne 000101: ExtCtrl = 01, Tuse1 = 0, Tuse2 = 0, isBr.
  - blez 000110, bgtz 000111, regimm 000001 (rt = 00000 bltz, rt = 00001 bgez): rs only, Tuse1 = 0, isBr.
  - j 000010: isJump.
  - jal 000011: isJump, ImmSel, RegWrite, Tnew = 1.
- Defaults:
  - Any unused operand has Tuse = 3 and ReadA = 0.
  - Unlisted opcode/funct behaves like nop: all 0, Tuse = 3.
- ifBr, on signed 32-bit values:
  - beq: RData1 == RData2; bne: RData1 != RData2.
  - blez: RData1 <= 0; bgtz: RData1 > 0.
  - bltz: RData1 < 0; bgez: RData1 >= 0.
  - Examples: 0x80000000 counts as negative; 0 satisfies blez and bgez.
  - Unknown regimm rt: isBr = 0, ifBr = 0.
- InDelaySlot:
  - Flop, set to (isBr | isJump | isJr) at each rising clk.
  - Asynchronous reset to 0.
  - No enable: the pipeline stall is handled outside, so the D instruction is held during a stall and the value re-evaluates identically.
- Latency: all other outputs combinational, zero cycles.

Decomposition:
- Shared package: opcode and funct localparams, ExtCtrl codes, TUSE_NONE = 3, Tnew codes.
- One natural sub-module: branch_cmp (Instr, RData1, RData2 -> ifBr).
- Main decode and AT table stay in the top.

Test Plan:
- addu $3,$1,$2 (0x00221821) -> RegWrite = 1, Tuse1 = 1, Tuse2 = 1, Tnew = 2, ReadA1 = 1, ReadA2 = 2, isBr = 0.
- beq $1,$2 with RData1 = RData2 = 5 -> isBr = 1, ifBr = 1, Tuse1 = 0, Tuse2 = 0.
  - Same instruction with RData2 = 6 -> ifBr = 0.
  - Next clk -> InDelaySlot = 1.
- bgez/bltz/blez/bgtz with RData1 = 0x80000000, 0, 1:
  - bltz = 1, 0, 0; bgez = 0, 1, 1; blez = 1, 1, 0; bgtz = 0, 0, 1.
- lw $4,8($5) -> Tnew = 3, ExtCtrl = 01, Tuse1 = 1, Tuse2 = 3, ReadA2 = 0.
  - sw $4,8($5) -> Tuse2 = 2, RegWrite = 0.
- jal 0x0C000010 -> isJump = 1, ImmSel = 1, RegWrite = 1, Tnew = 1.
  - jr $31 -> isJr = 1, Tuse1 = 0, ReadA1 = 31.
- mult $1,$2 -> MDUStart = 1, MDUClass = 1; mflo $3 -> MDUStart = 0, MDUClass = 1, Tnew = 2.
  - Instr = 0 -> all outputs 0, Tuse1 = Tuse2 = 3.
  - Assert reset mid-cycle -> InDelaySlot = 0 immediately.
